da_bank_write_scheduler: RTL and testbench
==========================================

Name: da_bank_write_scheduler

Overview:
- Sits between the USB3 cache read port (32-bit word stream) and the 24 downstream DA waveform/parameter RAM banks.
- Parses packet header words and decodes packet type.
- Sequences each payload into its 8-bank group: one-hot bank write enable, word address and registered data per accepted word.
- Reports packet completion and header errors.

Parameters:
- CA_WORDS, 32, words per bank for C/A-code packets (banks 0-7); range 1-63
- NAV_WORDS, 10, words per bank for navigation packets (banks 8-15); range 1-63
- PARAM_WORDS, 4, words per bank for parameter packets (banks 16-23); range 1-63
- TIMEOUT_CYC, 1024, idle cycles before payload abort (only with SCHED_TIMEOUT_EN)

Ports:
- rdclock  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_data  in  32  stream word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- wren_for_ram  out  24  one-hot bank write enable, registered
- ram_addr  out  6  word address within bank, registered
- ram_data  out  32  write data, registered
- busy  out  1  high in any payload state
- pkt_type  out  2  last decoded type: 1=CA, 2=NAV, 3=PARAM
- pkt_done  out  1  one-cycle pulse after last payload word of a packet
- hdr_err  out  1  one-cycle pulse on unknown header type or timeout abort

Behaviour:
- Reset (any state, mid-packet included): state=IDLE. wren_for_ram=0, ram_addr=0, ram_data=0, busy=0, pkt_type=0, pkt_done=0, hdr_err=0, in_ready=1. All counters 0. Partial packet discarded.
- Header word: in IDLE only, (in_data & 32'hFF0000FF)==32'hFF0000FF.
  - in_data[23:8]=16'h0000 -> CA.
  - 16'h000A -> NAV.
  - 16'h00AA -> PARAM.
  - Any other value -> hdr_err pulse, stay IDLE.
- States:
  - IDLE: in_ready=1. Valid header -> pkt_type set, enter CA/NAV/PARAM, wcnt=0, bcnt=0. Non-header words discarded silently, no error.
  - CA / NAV / PARAM (payload): in_ready=1, busy=1. base = 0 / 8 / 16; N = CA_WORDS / NAV_WORDS / PARAM_WORDS. Per accepted word, next cycle:
    - wren_for_ram = 1<<(base+bcnt)
    - ram_addr = wcnt
    - ram_data = in_data
  - Counter update per accepted payload word:
    - If wcnt==N-1: wcnt=0 and bcnt increments; if bcnt==7, go to DONE.
    - Otherwise wcnt increments.
  - Header-pattern words inside a payload are plain data; they are never re-parsed.
  - DONE: one cycle. in_ready=0, busy=0, pkt_done=1, wren_for_ram=0, then IDLE.
- Output timing:
  - Latency: accepted word -> write strobe exactly 1 cycle.
  - wren_for_ram is all-zero in any cycle not following an accepted payload word; at most one bit set.
  - in_valid may drop at any time in payload; counters hold; no writes are issued.
  - ram_addr and ram_data hold their last value when wren_for_ram=0.
- Packet length is exactly 8*N payload words. A word arriving in the DONE cycle is not accepted (in_ready=0).
- pkt_type holds until the next valid header.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN
- Defined:
  - A 16-bit idle counter runs in payload states. It clears on each accepted word.
  - On reaching TIMEOUT_CYC-1: hdr_err pulse, state -> IDLE, counters cleared, no pkt_done.
  - Banks already written are not rolled back.
- Undefined: no counter; the payload state waits indefinitely.

Test Plan:
- CA packet: header 32'hFF0000FF, then 256 words 0..255, continuous valid -> wren_for_ram steps 24'h000001..24'h000080. Each bit held 32 cycles; ram_addr 0..31 repeating; ram_data = stimulus word. pkt_done 1 cycle after word 255; pkt_type=1.
- NAV packet: header 32'hFF000AFF, then 80 words with in_valid toggling every other cycle -> writes only after accepted words; banks 8-15 (24'h000100..24'h008000), 10 words each; pkt_done once.
- Bad header 32'hFF0ABCFF in IDLE -> hdr_err single pulse, no wren_for_ram activity. A following PARAM header 32'hFF00AAFF plus 32 words -> banks 16-23, addr 0..3.
- Payload word equal to 32'hFF0000FF inside a NAV packet -> written as data; no type change; pkt_done still after exactly 80 words.
- rst asserted after 100 CA payload words -> all outputs 0 next cycle. A new NAV packet then completes normally from bank 8, addr 0.
- With SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: CA header, 5 words, then in_valid=0 for 20 cycles -> hdr_err at idle cycle 16, busy=0, no pkt_done. Without the macro: busy stays 1.

Source files
------------

// File: rtl/da_bank_write_scheduler.sv
// da_bank_write_scheduler: parses stream headers and writes each payload across its 8-bank RAM group; SCHED_TIMEOUT_EN adds a payload idle abort
module da_bank_write_scheduler #(
  parameter int CA_WORDS    = 32,
  parameter int NAV_WORDS   = 10,
  parameter int PARAM_WORDS = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        rdclock,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] wren_for_ram,
  output logic [5:0]  ram_addr,
  output logic [31:0] ram_data,
  output logic        busy,
  output logic [1:0]  pkt_type,
  output logic        pkt_done,
  output logic        hdr_err
);
  typedef enum logic [2:0] {IDLE, CA, NAV, PARAM, DONE} state_t;
  localparam logic [5:0] CA_LAST    = 6'(CA_WORDS - 1);
  localparam logic [5:0] NAV_LAST   = 6'(NAV_WORDS - 1);
  localparam logic [5:0] PARAM_LAST = 6'(PARAM_WORDS - 1);
  state_t      state, state_n;
  logic [5:0]  wcnt, wcnt_n, last;
  logic [2:0]  bcnt, bcnt_n;
  logic [4:0]  base;
  logic [1:0]  type_n;
  logic        err_n, acc, payload, is_hdr, tmo;
  assign in_ready = state != DONE;
  assign payload  = state == CA || state == NAV || state == PARAM;
  assign busy     = payload;
  assign pkt_done = state == DONE;
  assign acc      = in_valid && in_ready;
  assign is_hdr   = (in_data & 32'hFF0000FF) == 32'hFF0000FF;
  assign base     = state == NAV ? 5'd8 : state == PARAM ? 5'd16 : 5'd0;
  assign last     = state == NAV ? NAV_LAST : state == PARAM ? PARAM_LAST : CA_LAST;
`ifdef SCHED_TIMEOUT_EN
  logic [15:0] idle_cnt;
  // count payload cycles since the last accepted word
  always_ff @(posedge rdclock)
    idle_cnt <= (rst || !payload || acc) ? 16'd0 : idle_cnt + 16'd1;
  assign tmo = idle_cnt == 16'(TIMEOUT_CYC - 1);
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYC == 0;
  assign tmo = 1'b0;
`endif
  // next state, counters, decoded type and error pulse
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    bcnt_n  = bcnt;
    type_n  = pkt_type;
    err_n   = 1'b0;
    case (state)
      IDLE: if (acc && is_hdr) begin
        wcnt_n = 6'd0;
        bcnt_n = 3'd0;
        if (in_data[23:8] == 16'h0000) begin
          state_n = CA;
          type_n  = 2'd1;
        end else if (in_data[23:8] == 16'h000A) begin
          state_n = NAV;
          type_n  = 2'd2;
        end else if (in_data[23:8] == 16'h00AA) begin
          state_n = PARAM;
          type_n  = 2'd3;
        end else err_n = 1'b1;
      end
      CA, NAV, PARAM: if (acc) begin
        if (wcnt == last) begin
          wcnt_n = 6'd0;
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'd7) state_n = DONE;
        end else wcnt_n = wcnt + 6'd1;
      end else if (tmo) begin
        state_n = IDLE;
        wcnt_n  = 6'd0;
        bcnt_n  = 3'd0;
        err_n   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counters and registered RAM write port
  always_ff @(posedge rdclock) begin
    if (rst) begin
      state        <= IDLE;
      wcnt         <= 6'd0;
      bcnt         <= 3'd0;
      pkt_type     <= 2'd0;
      hdr_err      <= 1'b0;
      wren_for_ram <= 24'd0;
      ram_addr     <= 6'd0;
      ram_data     <= 32'd0;
    end else begin
      state        <= state_n;
      wcnt         <= wcnt_n;
      bcnt         <= bcnt_n;
      pkt_type     <= type_n;
      hdr_err      <= err_n;
      wren_for_ram <= (acc && payload) ? 24'd1 << (base + {2'b00, bcnt}) : 24'd0;
      if (acc && payload) begin
        ram_addr <= wcnt;
        ram_data <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_da_bank_write_scheduler.sv
// tb_da_bank_write_scheduler: directed vectors and packet sequences for the bank write scheduler
module tb_da_bank_write_scheduler;
  logic        rdclock = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] wren_for_ram;
  logic [5:0]  ram_addr;
  logic [31:0] ram_data;
  logic        busy;
  logic [1:0]  pkt_type;
  logic        pkt_done;
  logic        hdr_err;
  int          total = 0;
  int          bad = 0;
  logic [5:0]  last_addr = 6'd0;
  logic [31:0] last_data = 32'd0;
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [23:0] w;
    logic        b, dn, e, r;
  } vec_t;
  vec_t tbl[5];
  da_bank_write_scheduler #(.TIMEOUT_CYC(16)) dut (
    .rdclock(rdclock), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wren_for_ram(wren_for_ram), .ram_addr(ram_addr),
    .ram_data(ram_data), .busy(busy), .pkt_type(pkt_type), .pkt_done(pkt_done),
    .hdr_err(hdr_err)
  );
  always #5 rdclock = ~rdclock;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge rdclock);
    #1;
  endtask
  task automatic ex(input string nm, input logic [23:0] w, input logic b, input logic dn,
                    input logic e, input logic r);
    chk({nm, ".wren"}, {8'd0, wren_for_ram}, {8'd0, w});
    chk({nm, ".addr"}, {26'd0, ram_addr}, {26'd0, last_addr});
    chk({nm, ".data"}, ram_data, last_data);
    chk({nm, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({nm, ".done"}, {31'd0, pkt_done}, {31'd0, dn});
    chk({nm, ".err"}, {31'd0, hdr_err}, {31'd0, e});
    chk({nm, ".ready"}, {31'd0, in_ready}, {31'd0, r});
  endtask
  task automatic run_pkt(input string nm, input logic [31:0] hdr, input int base, input int n,
                         input logic [1:0] typ, input logic [31:0] dbase, input bit tog,
                         input int inj);
    logic [31:0] w;
    logic [23:0] one;
    one = 24'd1;
    drive(1'b1, hdr);
    ex({nm, ".hdr"}, 24'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk({nm, ".type"}, {30'd0, pkt_type}, {30'd0, typ});
    for (int i = 0; i < 8 * n; i++) begin
      if (tog) begin
        drive(1'b0, 32'hDEAD0000 + i);
        ex({nm, ".gap"}, 24'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      w = (i == inj) ? 32'hFF0000FF : dbase + i;
      drive(1'b1, w);
      last_addr = 6'(i % n);
      last_data = w;
      if (i == 8 * n - 1) ex({nm, ".last"}, one << (base + i / n), 1'b0, 1'b1, 1'b0, 1'b0);
      else ex({nm, ".pay"}, one << (base + i / n), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    chk({nm, ".type_end"}, {30'd0, pkt_type}, {30'd0, typ});
    drive(1'b1, 32'hFF0000FF);
    ex({nm, ".post"}, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'd0);
    ex({nm, ".idle"}, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    int errs, dones, first;
    tbl[0] = '{1'b1, 32'hFF0ABCFF, 24'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 32'hFF0ABCFF, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 32'h12345678, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'hFF0000AA, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'hFE0000FF, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'd0;
    repeat (2) @(posedge rdclock);
    #1;
    ex("reset", 24'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.type", {30'd0, pkt_type}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].v, tbl[i].d);
      ex($sformatf("vec%0d", i), tbl[i].w, tbl[i].b, tbl[i].dn, tbl[i].e, tbl[i].r);
    end
    chk("vec.type", {30'd0, pkt_type}, 32'd0);
    run_pkt("param", 32'hFF00AAFF, 16, 4, 2'd3, 32'hA0000000, 1'b0, -1);
    run_pkt("ca", 32'hFF0000FF, 0, 32, 2'd1, 32'd0, 1'b0, -1);
    run_pkt("nav_tog", 32'hFF000AFF, 8, 10, 2'd2, 32'hC0000000, 1'b1, -1);
    run_pkt("nav_inj", 32'hFF000AFF, 8, 10, 2'd2, 32'hB0000000, 1'b0, 37);
    drive(1'b1, 32'hFF0000FF);
    for (int i = 0; i < 100; i++) drive(1'b1, 32'h5000 + i);
    chk("mid.busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    drive(1'b1, 32'h55);
    last_addr = 6'd0;
    last_data = 32'd0;
    ex("midrst", 24'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst.type", {30'd0, pkt_type}, 32'd0);
    rst = 1'b0;
    run_pkt("nav_after", 32'hFF000AFF, 8, 10, 2'd2, 32'h70000000, 1'b0, -1);
    drive(1'b1, 32'hFF0000FF);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h900 + i);
    errs = 0;
    dones = 0;
    first = 0;
    for (int j = 1; j <= 20; j++) begin
      drive(1'b0, 32'd0);
      if (hdr_err) begin
        errs++;
        if (first == 0) first = j;
      end
      if (pkt_done) dones++;
      if (wren_for_ram != 24'd0) chk("to.wren", {8'd0, wren_for_ram}, 32'd0);
    end
    chk("to.done", dones, 0);
`ifdef SCHED_TIMEOUT_EN
    chk("to.errs", errs, 1);
    chk("to.at", first, 16);
    chk("to.busy", {31'd0, busy}, 32'd0);
`else
    chk("to.errs", errs, 0);
    chk("to.busy", {31'd0, busy}, 32'd1);
`endif
    rst = 1'b1;
    drive(1'b0, 32'd0);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
